// File: rtl/wave_gen_param_if.sv
// Configuration port of wave_gen_param: valid/ready offer of mode, limits,
// step and prescaler terminal count.
interface wave_gen_param_if #(
   parameter int WIDTH = 12,
   parameter int DIV_W = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [1:0]       cfg_mode;
   logic [WIDTH-1:0] cfg_lo;
   logic [WIDTH-1:0] cfg_hi;
   logic [WIDTH-1:0] cfg_step;
   logic [DIV_W-1:0] cfg_div;

   modport master (
      output cfg_valid, cfg_mode, cfg_lo, cfg_hi, cfg_step, cfg_div,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_mode, cfg_lo, cfg_hi, cfg_step, cfg_div,
      output cfg_ready
   );
endinterface

// File: rtl/wave_gen_param.sv
// Periodic triangle / saw-up / saw-down / square generator for a WIDTH-bit DAC.
// New configurations are held pending and swapped in only on a period boundary.
module wave_gen_param #(
   parameter int WIDTH = 12,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   wave_gen_param_if.slave  cfg,
   output logic [WIDTH-1:0] wave,
   output logic             period_start,
   output logic             cfg_err
);

   typedef enum logic [1:0] {
      MODE_TRI   = 2'b00,
      MODE_SAWUP = 2'b01,
      MODE_SAWDN = 2'b10,
      MODE_SQR   = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   mode_e            mode_q,  mode_d;
   logic [WIDTH-1:0] lo_q,    lo_d;
   logic [WIDTH-1:0] hi_q,    hi_d;
   logic [WIDTH-1:0] step_q,  step_d;
   logic [DIV_W-1:0] div_q,   div_d;
   logic [WIDTH-1:0] acc_q,   acc_d;
   dir_e             dir_q,   dir_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [WIDTH-1:0] wave_q,  wave_d;
   logic             ps_q,    ps_d;
   logic             err_q,   err_d;
   logic             ready_q, ready_d;
   logic             pend_q,  pend_d;
   mode_e            pmode_q, pmode_d;
   logic [WIDTH-1:0] plo_q,   plo_d;
   logic [WIDTH-1:0] phi_q,   phi_d;
   logic [WIDTH-1:0] pstep_q, pstep_d;
   logic [DIV_W-1:0] pdiv_q,  pdiv_d;

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   lo_step_s;
   logic             up_hit_s;
   logic             dn_hit_s;
   logic [WIDTH-1:0] nacc_s;
   dir_e             ndir_s;
   logic             bnd_s;
   logic             tick_s;
   logic             xfer_s;

   function automatic logic [WIDTH-1:0] wave_of(
      input mode_e            m,
      input logic [WIDTH-1:0] a,
      input dir_e             d,
      input logic [WIDTH-1:0] lo,
      input logic [WIDTH-1:0] hi
   );
      logic [WIDTH-1:0] w;
      if (m == MODE_SQR) begin
         w = (d == DIR_DOWN) ? hi : lo;
      end else begin
         w = a;
      end
      return w;
   endfunction

   // One-tick advance of acc/dir under the active config; sums are WIDTH+1 bits wide
   always_comb begin
      sum_s     = {1'b0, acc_q} + {1'b0, step_q};
      lo_step_s = {1'b0, lo_q} + {1'b0, step_q};
      up_hit_s  = (sum_s >= {1'b0, hi_q});
      dn_hit_s  = ({1'b0, acc_q} <= lo_step_s);
      nacc_s    = acc_q;
      ndir_s    = dir_q;
      bnd_s     = 1'b0;
      case (mode_q)
         MODE_TRI, MODE_SQR: begin
            if (dir_q == DIR_UP) begin
               if (up_hit_s) begin
                  nacc_s = hi_q;
                  ndir_s = DIR_DOWN;
               end else begin
                  nacc_s = sum_s[WIDTH-1:0];
               end
            end else begin
               if (dn_hit_s) begin
                  nacc_s = lo_q;
                  ndir_s = DIR_UP;
                  bnd_s  = 1'b1;
               end else begin
                  nacc_s = acc_q - step_q;
               end
            end
         end
         MODE_SAWUP: begin
            if (acc_q == hi_q) begin
               nacc_s = lo_q;
               bnd_s  = 1'b1;
            end else begin
               nacc_s = up_hit_s ? hi_q : sum_s[WIDTH-1:0];
            end
         end
         MODE_SAWDN: begin
            if (acc_q == lo_q) begin
               nacc_s = hi_q;
               bnd_s  = 1'b1;
            end else begin
               nacc_s = dn_hit_s ? lo_q : (acc_q - step_q);
            end
         end
         default: begin
            nacc_s = acc_q;
         end
      endcase
   end

   // Next-state: prescaler, waveform update, pending apply and config handshake
   always_comb begin
      mode_d  = mode_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      step_d  = step_q;
      div_d   = div_q;
      acc_d   = acc_q;
      dir_d   = dir_q;
      presc_d = presc_q;
      wave_d  = wave_q;
      ps_d    = 1'b0;
      err_d   = 1'b0;
      pend_d  = pend_q;
      pmode_d = pmode_q;
      plo_d   = plo_q;
      phi_d   = phi_q;
      pstep_d = pstep_q;
      pdiv_d  = pdiv_q;
      tick_s  = enable && (presc_q == div_q);
      xfer_s  = cfg.cfg_valid && ready_q;

      if ((pend_q && !enable) || (tick_s && bnd_s && pend_q)) begin
         // Swap in the pending config; the new period starts at the new lo
         mode_d  = pmode_q;
         lo_d    = plo_q;
         hi_d    = phi_q;
         step_d  = pstep_q;
         div_d   = pdiv_q;
         acc_d   = plo_q;
         dir_d   = DIR_UP;
         wave_d  = plo_q;
         presc_d = {DIV_W{1'b0}};
         pend_d  = 1'b0;
         ps_d    = enable;
      end else if (enable) begin
         presc_d = tick_s ? {DIV_W{1'b0}} : (presc_q + DIV_W'(1));
         if (tick_s) begin
            acc_d  = nacc_s;
            dir_d  = ndir_s;
            wave_d = wave_of(mode_q, nacc_s, ndir_s, lo_q, hi_q);
            ps_d   = bnd_s;
         end else begin
            acc_d  = acc_q;
         end
      end else begin
         presc_d = presc_q;
      end

      if (xfer_s) begin
         if ((cfg.cfg_lo >= cfg.cfg_hi) || (cfg.cfg_step == {WIDTH{1'b0}})) begin
            err_d = 1'b1;
         end else begin
            pend_d  = 1'b1;
            pmode_d = mode_e'(cfg.cfg_mode);
            plo_d   = cfg.cfg_lo;
            phi_d   = cfg.cfg_hi;
            pstep_d = cfg.cfg_step;
            pdiv_d  = cfg.cfg_div;
         end
      end else begin
         err_d = 1'b0;
      end

      ready_d = !pend_d;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q  <= MODE_TRI;
         lo_q    <= {WIDTH{1'b0}};
         hi_q    <= {WIDTH{1'b1}};
         step_q  <= {{(WIDTH-1){1'b0}}, 1'b1};
         div_q   <= {DIV_W{1'b0}};
         acc_q   <= {WIDTH{1'b0}};
         dir_q   <= DIR_UP;
         presc_q <= {DIV_W{1'b0}};
         wave_q  <= {WIDTH{1'b0}};
         ps_q    <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         pend_q  <= 1'b0;
         pmode_q <= MODE_TRI;
         plo_q   <= {WIDTH{1'b0}};
         phi_q   <= {WIDTH{1'b0}};
         pstep_q <= {WIDTH{1'b0}};
         pdiv_q  <= {DIV_W{1'b0}};
      end else begin
         mode_q  <= mode_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         step_q  <= step_d;
         div_q   <= div_d;
         acc_q   <= acc_d;
         dir_q   <= dir_d;
         presc_q <= presc_d;
         wave_q  <= wave_d;
         ps_q    <= ps_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         pend_q  <= pend_d;
         pmode_q <= pmode_d;
         plo_q   <= plo_d;
         phi_q   <= phi_d;
         pstep_q <= pstep_d;
         pdiv_q  <= pdiv_d;
      end
   end

   assign wave          = wave_q;
   assign period_start  = ps_q;
   assign cfg_err       = err_q;
   assign cfg.cfg_ready = ready_q;

endmodule

// File: tb/tb_wave_gen_param.sv
// Bench for wave_gen_param: directed scenarios plus random traffic, every cycle
// compared against a period-table reference model.
module tb_wave_gen_param;
   localparam int WIDTH = 12;
   localparam int DIV_W = 8;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
   logic [WIDTH-1:0] wave;
   logic             period_start;
   logic             cfg_err;

   wave_gen_param_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) cfg_bus ();

   wave_gen_param #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .cfg          (cfg_bus.slave),
      .wave         (wave),
      .period_start (period_start),
      .cfg_err      (cfg_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: one period of output values as a table, walked by a position
   int m_list[$];
   int m_pos, m_presc;
   int m_mode, m_lo, m_hi, m_step, m_div;
   bit m_pend;
   int p_mode, p_lo, p_hi, p_step, p_div;
   int m_wave;
   bit m_ps, m_err, m_ready;

   function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
   function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

   task automatic build_list(input int mode, input int lo, input int hi, input int step,
                             output int start);
      int a;
      m_list.delete();
      start = 0;
      if (mode == 1) begin
         a = lo; m_list.push_back(a);
         while (a != hi) begin a = imin(a + step, hi); m_list.push_back(a); end
      end else if (mode == 2) begin
         a = hi; m_list.push_back(a);
         while (a != lo) begin a = imax(a - step, lo); m_list.push_back(a); end
         start = m_list.size() - 1;
      end else begin
         a = lo; m_list.push_back(lo);
         while (a != hi) begin
            a = imin(a + step, hi);
            m_list.push_back((mode == 3 && a != hi) ? lo : a);
         end
         while (1) begin
            a = imax(a - step, lo);
            if (a == lo) break;
            m_list.push_back((mode == 3) ? hi : a);
         end
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_lo = 0; m_hi = MAXV; m_step = 1; m_div = 0;
      build_list(m_mode, m_lo, m_hi, m_step, m_pos);
      m_presc = 0; m_pend = 0; m_wave = 0; m_ps = 0; m_err = 0; m_ready = 1;
   endtask

   task automatic model_apply();
      m_mode = p_mode; m_lo = p_lo; m_hi = p_hi; m_step = p_step; m_div = p_div;
      build_list(m_mode, m_lo, m_hi, m_step, m_pos);
      m_wave = m_list[m_pos];
      m_presc = 0; m_pend = 0;
   endtask

   task automatic model_step();
      bit xfer, tick;
      int np;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_ps = 0; m_err = 0;
      xfer = cfg_bus.cfg_valid && m_ready;
      if (m_pend && !enable) begin
         model_apply();
      end else if (enable) begin
         tick = (m_presc == m_div);
         m_presc = tick ? 0 : m_presc + 1;
         if (tick) begin
            np = (m_pos + 1) % m_list.size();
            if (np == 0) begin
               m_ps = 1;
               if (m_pend) model_apply();
               else m_pos = 0;
            end else begin
               m_pos = np;
            end
            m_wave = m_list[m_pos];
         end
      end
      if (xfer) begin
         if (int'(cfg_bus.cfg_lo) >= int'(cfg_bus.cfg_hi) || cfg_bus.cfg_step == '0) begin
            m_err = 1;
         end else begin
            m_pend = 1;
            p_mode = int'(cfg_bus.cfg_mode); p_lo = int'(cfg_bus.cfg_lo);
            p_hi = int'(cfg_bus.cfg_hi); p_step = int'(cfg_bus.cfg_step);
            p_div = int'(cfg_bus.cfg_div);
         end
      end
      m_ready = !m_pend;
   endtask

   task automatic do_cycle();
      model_step();
      @(posedge clk);
      #1;
      chk_eq("wave", int'(wave), m_wave);
      chk_eq("period_start", int'(period_start), int'(m_ps));
      chk_eq("cfg_err", int'(cfg_err), int'(m_err));
      chk_eq("cfg_ready", int'(cfg_bus.cfg_ready), int'(m_ready));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) do_cycle();
   endtask

   task automatic offer(input int mode, input int lo, input int hi, input int step, input int dv);
      cfg_bus.cfg_mode  = 2'(mode);
      cfg_bus.cfg_lo    = WIDTH'(lo);
      cfg_bus.cfg_hi    = WIDTH'(hi);
      cfg_bus.cfg_step  = WIDTH'(step);
      cfg_bus.cfg_div   = DIV_W'(dv);
      cfg_bus.cfg_valid = 1'b1;
      do_cycle();
      cfg_bus.cfg_valid = 1'b0;
   endtask

   int exp2[8] = '{13, 16, 19, 20, 17, 14, 11, 10};
   int first_ps;
   int ps_at[$];

   initial begin
      rst_n = 1'b0; enable = 1'b0;
      cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_mode = 2'b00;
      cfg_bus.cfg_lo = '0; cfg_bus.cfg_hi = '0; cfg_bus.cfg_step = '0; cfg_bus.cfg_div = '0;
      run(2);
      chk_eq("rst_wave", int'(wave), 0);
      chk_eq("rst_ready", int'(cfg_bus.cfg_ready), 1);
      rst_n = 1'b1;

      // T1: default triangle, first boundary after 8190 ticks
      enable = 1'b1;
      first_ps = 0;
      for (int i = 1; i <= 8200; i++) begin
         do_cycle();
         if (i == 4095) chk_eq("t1_peak", int'(wave), 4095);
         if (period_start && first_ps == 0) first_ps = i;
      end
      chk_eq("t1_period", first_ps, 8190);

      // T2: apply while disabled, then one full period
      enable = 1'b0;
      offer(0, 10, 20, 3, 0);
      do_cycle();
      chk_eq("t2_apply_wave", int'(wave), 10);
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         do_cycle();
         chk_eq("t2_seq", int'(wave), exp2[i]);
         chk_eq("t2_ps", int'(period_start), (i == 7) ? 1 : 0);
      end

      // T3: same triangle with prescaler 2
      offer(0, 10, 20, 3, 2);
      for (int i = 0; i < 100; i++) begin
         do_cycle();
         if (period_start) ps_at.push_back(i);
      end
      chk_eq("t3_period", (ps_at.size() >= 3) ? ps_at[2] - ps_at[1] : -1, 24);

      // T4: saw-up then square
      offer(1, 0, 7, 2, 0);
      run(60);
      offer(3, 0, 7, 2, 0);
      run(60);

      // T5: rejected config, then a valid one mid-period
      offer(0, 20, 10, 3, 0);
      run(5);
      offer(2, 0, 10, 0, 0);
      run(5);
      run(3);
      offer(0, 100, 200, 7, 1);
      run(200);

      // T6: reset with a config pending
      offer(0, 5, 50, 1, 0);
      run(3);
      rst_n = 1'b0;
      do_cycle();
      chk_eq("t6_rst_wave", int'(wave), 0);
      rst_n = 1'b1;
      run(20);

      // Random traffic
      for (int i = 0; i < 20000; i++) begin
         int lo, hi, md;
         enable = ($urandom % 8) != 0;
         rst_n  = ($urandom % 3000) != 0;
         md = $urandom % 4;
         lo = $urandom_range(0, 4000);
         hi = (($urandom % 8) == 0) ? $urandom_range(0, lo) : lo + $urandom_range(1, 90);
         cfg_bus.cfg_mode  = 2'(md);
         cfg_bus.cfg_lo    = WIDTH'(lo);
         cfg_bus.cfg_hi    = WIDTH'(hi);
         cfg_bus.cfg_step  = WIDTH'((($urandom % 10) == 0) ? 0 : $urandom_range(1, 120));
         cfg_bus.cfg_div   = DIV_W'($urandom_range(0, 3));
         cfg_bus.cfg_valid = ($urandom % 12) == 0;
         do_cycle();
      end
      cfg_bus.cfg_valid = 1'b0;
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
